// File: rtl/video_fetch_wide.sv
// video_fetch_wide: gathers WORDS 16-bit arbiter words per fetch cycle, byte-swaps them into pic_bits on fetch_sync.
// Latency: a stored word reaches pic_bits one clk after the first fetch_sync following its store.
// Backpressure: none; strobes arriving with the buffer full are dropped and flagged on fetch_ovf.
//
// Ports:
//   clk, rst_n (synchronous, active-low), cend / pre_cend (sync strobes), fetch_start / fetch_end (window pulses)
//   video_data / video_strobe (arbiter word in), video_go (request), fetch_sync (hand-over pulse),
//   pic_bits (16*WORDS picture bits), fetch_ovf (dropped strobe), fetch_unf (short hand-over)
// Optional feature macro: VIDEO_FETCH_UNDERFLOW_EN builds the word counter behind fetch_unf;
// when undefined fetch_unf is tied low.
module video_fetch_wide #(
    parameter int WORDS    = 4,
    parameter int SYNC_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cend,
    input  logic                  pre_cend,
    input  logic                  fetch_start,
    input  logic                  fetch_end,
    input  logic [15:0]           video_data,
    input  logic                  video_strobe,
    output logic                  video_go,
    output logic                  fetch_sync,
    output logic [16*WORDS-1:0]   pic_bits,
    output logic                  fetch_ovf,
    output logic                  fetch_unf
);
    localparam int PW = $clog2(WORDS);
    localparam int CW = $clog2(SYNC_LEN);

    logic                  go_q, go_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sync_q, sync_d;
    logic                  clr_q, clr_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  full_q, full_d;
    logic [16*WORDS-1:0]   store_q, store_d;
    logic [16*WORDS-1:0]   pic_q, pic_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        // Start has priority over end when both pulse together.
        go_d = go_q;
        if (fetch_start) begin
            go_d = 1'b1;
        end else if (fetch_end) begin
            go_d = 1'b0;
        end

        // Counter advances on cend only; a start coinciding with cend re-phases the fetch cycle.
        cnt_d = cnt_q;
        if (cend) begin
            cnt_d = fetch_start ? '0 : cnt_q + CW'(1);
        end

        // pre_cend looks one clk ahead so both pulses line up with the cend clk.
        sync_d = pre_cend && (cnt_q == CW'(1));
        clr_d  = pre_cend && (cnt_q == '0);

        ptr_d   = ptr_q;
        full_d  = full_q;
        store_d = store_q;
        ovf_d   = 1'b0;
        if (clr_q) begin
            // Clear and a coincident store merge: the word lands at index 0.
            ptr_d  = '0;
            full_d = 1'b0;
            if (video_strobe) begin
                store_d[15:0] = video_data;
                ptr_d         = PW'(1);
            end
        end else if (video_strobe) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                store_d[16*ptr_q +: 16] = video_data;
                ptr_d  = ptr_q + PW'(1);
                full_d = (ptr_q == PW'(WORDS - 1));
            end
        end

        // Hand-over samples the store before this clk's strobe is written.
        pic_d = pic_q;
        if (sync_q) begin
            for (int i = 0; i < WORDS; i++) begin
                pic_d[16*i +: 16] = {store_q[16*i +: 8], store_q[16*i+8 +: 8]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            go_q    <= 1'b0;
            cnt_q   <= '0;
            sync_q  <= 1'b0;
            clr_q   <= 1'b0;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            store_q <= '0;
            pic_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            go_q    <= go_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            clr_q   <= clr_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            store_q <= store_d;
            pic_q   <= pic_d;
            ovf_q   <= ovf_d;
        end
    end

    assign video_go   = go_q;
    assign fetch_sync = sync_q;
    assign pic_bits   = pic_q;
    assign fetch_ovf  = ovf_q;

`ifdef VIDEO_FETCH_UNDERFLOW_EN
    localparam int NW = PW + 1;

    logic [NW-1:0] wcnt_q, wcnt_d;
    logic          unf_q, unf_d;

    always_comb begin
        // Counts words accepted since the last clear; saturates at WORDS because full blocks stores.
        wcnt_d = wcnt_q;
        if (clr_q) begin
            wcnt_d = video_strobe ? NW'(1) : '0;
        end else if (video_strobe && !full_q) begin
            wcnt_d = wcnt_q + NW'(1);
        end
        unf_d = sync_q && go_q && (wcnt_q < NW'(WORDS));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            unf_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            unf_q  <= unf_d;
        end
    end

    assign fetch_unf = unf_q;
`else
    assign fetch_unf = 1'b0;
`endif

endmodule

// File: tb/tb_video_fetch_wide.sv
// Bench for video_fetch_wide (WORDS=4, SYNC_LEN=16, cend every 4 clk).
// Scenario tasks check against a behavioural model of fill count, store and hand-over.
module tb_video_fetch_wide;
    localparam int W   = 4;
    localparam int SL  = 16;
    localparam int PER = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cend = 1'b0;
    logic            pre_cend = 1'b0;
    logic            fetch_start = 1'b0;
    logic            fetch_end = 1'b0;
    logic [15:0]     video_data = '0;
    logic            video_strobe = 1'b0;
    logic            video_go;
    logic            fetch_sync;
    logic [16*W-1:0] pic_bits;
    logic            fetch_ovf;
    logic            fetch_unf;

    video_fetch_wide #(.WORDS(W), .SYNC_LEN(SL)) dut (
        .clk(clk), .rst_n(rst_n), .cend(cend), .pre_cend(pre_cend),
        .fetch_start(fetch_start), .fetch_end(fetch_end),
        .video_data(video_data), .video_strobe(video_strobe),
        .video_go(video_go), .fetch_sync(fetch_sync), .pic_bits(pic_bits),
        .fetch_ovf(fetch_ovf), .fetch_unf(fetch_unf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ph     = 0;

    // Behavioural model
    int              m_cnt = 0;
    bit              m_go = 0;
    logic [15:0]     m_st [W];
    int              m_fill = 0;
    logic [16*W-1:0] m_pic = '0;
    bit              m_sync = 0;
    bit              m_clr = 0;
    bit              m_ovf = 0;
    bit              m_unf = 0;
    bit              m_ho = 0;

`ifdef VIDEO_FETCH_UNDERFLOW_EN
    localparam bit UNF_ON = 1'b1;
`else
    localparam bit UNF_ON = 1'b0;
`endif

    function automatic logic [15:0] swp(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    // Drive one clk of inputs, advance the model at the edge, return #1 after it.
    task automatic step(input bit stb, input logic [15:0] d, input bit fs, input bit fe);
        bit sync_now, clr_now;
        cend         = (ph == 0);
        pre_cend     = (ph == PER - 1);
        video_strobe = stb;
        video_data   = d;
        fetch_start  = fs;
        fetch_end    = fe;
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0; m_go = 0; m_fill = 0; m_pic = '0;
            m_sync = 0; m_clr = 0; m_ovf = 0; m_unf = 0; m_ho = 0;
            for (int i = 0; i < W; i++) m_st[i] = '0;
        end else begin
            sync_now = m_sync;
            clr_now  = m_clr;
            m_ho     = sync_now;
            m_sync   = pre_cend && (m_cnt == 1);
            m_clr    = pre_cend && (m_cnt == 0);
            m_ovf    = 0;
            m_unf    = 0;
            if (sync_now) begin
                for (int i = 0; i < W; i++) m_pic[16*i +: 16] = swp(m_st[i]);
                m_unf = UNF_ON && m_go && (m_fill < W);
            end
            if (clr_now) m_fill = 0;
            if (stb) begin
                if (m_fill >= W) m_ovf = 1;
                else begin
                    m_st[m_fill] = d;
                    m_fill++;
                end
            end
            if (fs) m_go = 1;
            else if (fe) m_go = 0;
            if (cend) m_cnt = fs ? 0 : (m_cnt + 1) % SL;
        end
        #1;
        ph = (ph + 1) % PER;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0);
    endtask

    // Returns 1 when the model says the next clk is a pointer-clear clk.
    task automatic wait_clr(output bit ok);
        int n = 0;
        while (!m_clr && n < 200) begin
            step(0, 16'h0, 0, 0);
            n++;
        end
        ok = m_clr;
    endtask

    // Runs until just after a hand-over edge.
    task automatic run_to_handover(output bit ok);
        int n = 0;
        ok = 0;
        while (n < 200 && !ok) begin
            step(0, 16'h0, 0, 0);
            n++;
            ok = m_ho;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1, 16'($urandom), 0, 0);
            n_chk++;
            if ({video_go, fetch_sync, fetch_ovf, fetch_unf, pic_bits} !== '0)
                $display("FAIL reset_outputs clk%0d: got %b/%b/%b/%b %h want all 0",
                         c, video_go, fetch_sync, fetch_ovf, fetch_unf, pic_bits);
            else n_pass++;
        end
        rst_n = 1'b1;
        idle(2);
        n_chk++;
        if ({video_go, fetch_sync, pic_bits} !== '0)
            $display("FAIL reset_hold: got go=%b sync=%b pic=%h want 0", video_go, fetch_sync, pic_bits);
        else n_pass++;
    endtask

    task automatic test_window();
        step(0, 16'h0, 1, 1);
        n_chk++;
        if (video_go !== 1'b1) $display("FAIL window_start_wins: got %b want 1", video_go);
        else n_pass++;
        step(0, 16'h0, 0, 1);
        n_chk++;
        if (video_go !== 1'b0) $display("FAIL window_end: got %b want 0", video_go);
        else n_pass++;
    endtask

    task automatic test_nominal();
        bit ok;
        while (ph != 0) step(0, 16'h0, 0, 0);
        step(0, 16'h0, 1, 0);
        wait_clr(ok);
        n_chk++;
        if (!ok) $display("FAIL nominal_clear_timeout: got none want clear");
        else n_pass++;
        step(1, 16'h1122, 0, 0);
        step(1, 16'h3344, 0, 0);
        step(1, 16'h5566, 0, 0);
        step(1, 16'h7788, 0, 0);
        n_chk++;
        if (fetch_sync !== 1'b1) $display("FAIL nominal_sync_pulse: got %b want 1", fetch_sync);
        else n_pass++;
        step(0, 16'h0, 0, 0);
        n_chk++;
        if (pic_bits !== 64'h8877_6655_4433_2211)
            $display("FAIL nominal_pic: got %h want %h", pic_bits, 64'h8877_6655_4433_2211);
        else n_pass++;
        n_chk++;
        if ({fetch_ovf, fetch_unf, fetch_sync} !== 3'b000)
            $display("FAIL nominal_flags: got ovf=%b unf=%b sync=%b want 0", fetch_ovf, fetch_unf, fetch_sync);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        logic [15:0] d0;
        d0 = 16'($urandom);
        wait_clr(ok);
        step(1, d0, 0, 0);
        for (int i = 1; i < W; i++) step(1, 16'($urandom), 0, 0);
        n_chk++;
        if (fetch_ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", fetch_ovf);
        else n_pass++;
        step(1, 16'($urandom), 0, 0);
        n_chk++;
        if (fetch_ovf !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", fetch_ovf);
        else n_pass++;
        step(0, 16'h0, 0, 0);
        n_chk++;
        if (fetch_ovf !== 1'b0) $display("FAIL ovf_one_clk: got %b want 0", fetch_ovf);
        else n_pass++;
        run_to_handover(ok);
        n_chk++;
        if (!ok || pic_bits[15:0] !== swp(d0))
            $display("FAIL ovf_word0_kept: got %h want %h", pic_bits[15:0], swp(d0));
        else n_pass++;
        n_chk++;
        if (pic_bits !== m_pic) $display("FAIL ovf_pic: got %h want %h", pic_bits, m_pic);
        else n_pass++;
    endtask

    task automatic test_merge();
        bit ok;
        logic [15:0] d1;
        logic [16*W-1:0] prev;
        d1 = 16'($urandom);
        prev = pic_bits;
        wait_clr(ok);
        step(1, 16'hABCD, 0, 0);
        step(1, d1, 0, 0);
        run_to_handover(ok);
        n_chk++;
        if (!ok || pic_bits[31:0] !== {swp(d1), 16'hCDAB})
            $display("FAIL merge_idx01: got %h want %h", pic_bits[31:0], {swp(d1), 16'hCDAB});
        else n_pass++;
        n_chk++;
        if (pic_bits[16*W-1:32] !== prev[16*W-1:32])
            $display("FAIL merge_upper_kept: got %h want %h", pic_bits[16*W-1:32], prev[16*W-1:32]);
        else n_pass++;
    endtask

    task automatic test_underflow();
        bit ok;
        logic [16*W-1:0] prev;
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        wait_clr(ok);
        prev = pic_bits;
        step(1, a, 0, 0);
        step(0, 16'h0, 0, 0);
        step(1, b, 0, 0);
        run_to_handover(ok);
        n_chk++;
        if (!ok || fetch_unf !== UNF_ON) $display("FAIL unf_pulse: got %b want %b", fetch_unf, UNF_ON);
        else n_pass++;
        n_chk++;
        if (pic_bits !== {prev[16*W-1:32], swp(b), swp(a)})
            $display("FAIL unf_pic: got %h want %h", pic_bits, {prev[16*W-1:32], swp(b), swp(a)});
        else n_pass++;
        step(0, 16'h0, 0, 0);
        n_chk++;
        if (fetch_unf !== 1'b0) $display("FAIL unf_one_clk: got %b want 0", fetch_unf);
        else n_pass++;
    endtask

    task automatic test_rephase();
        int n = 0;
        while (!(m_cnt == 7 && ph == 0) && n < 300) begin
            step(0, 16'h0, 0, 0);
            n++;
        end
        step(0, 16'h0, 1, 0);
        // Counter is 0 after this cend; clear comes one cend later, sync the cend after that.
        n = 0;
        while (fetch_sync !== 1'b1 && n < 100) begin
            step(0, 16'h0, 0, 0);
            n++;
        end
        n_chk++;
        if (n != 2 * PER - 1) $display("FAIL rephase_delay: got %0d clk want %0d", n, 2 * PER - 1);
        else n_pass++;
        n = 0;
        do begin
            step(0, 16'h0, 0, 0);
            n++;
        end while (fetch_sync !== 1'b1 && n < 200);
        n_chk++;
        if (n != SL * PER) $display("FAIL sync_period: got %0d clk want %0d", n, SL * PER);
        else n_pass++;
    endtask

    task automatic test_midreset();
        bit ok;
        wait_clr(ok);
        step(1, 16'($urandom), 0, 0);
        step(1, 16'($urandom), 0, 0);
        rst_n = 1'b0;
        step(0, 16'h0, 0, 0);
        rst_n = 1'b1;
        run_to_handover(ok);
        n_chk++;
        if (!ok || pic_bits !== '0) $display("FAIL midreset_discard: got %h want 0", pic_bits);
        else n_pass++;
    endtask

    task automatic test_random();
        bit stb, fs, fe;
        for (int c = 0; c < 400; c++) begin
            stb = ($urandom % 3) == 0;
            fs  = ($urandom % 40) == 0;
            fe  = ($urandom % 40) == 0;
            step(stb, 16'($urandom), fs, fe);
            n_chk++;
            if ({video_go, fetch_sync, fetch_ovf, fetch_unf, pic_bits} !== {m_go, m_sync, m_ovf, m_unf, m_pic})
                $display("FAIL rnd_c%0d: got go=%b sync=%b ovf=%b unf=%b pic=%h want %b %b %b %b %h",
                         c, video_go, fetch_sync, fetch_ovf, fetch_unf, pic_bits,
                         m_go, m_sync, m_ovf, m_unf, m_pic);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) m_st[i] = '0;
        test_reset();
        test_window();
        test_nominal();
        test_overflow();
        test_merge();
        test_underflow();
        test_rephase();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
